// File: rtl/cam_pkg.sv
// Shared constants for the camera capture path.
//   CAM_PIX_WIDTH       : pixel word width
//   CAM_FIFO_ADR_WIDTH  : default stream FIFO address width
//   CAM_FIFO_AF_MARGIN  : default almost-full distance below DEPTH
//   CAM_FIFO_AE_THRESH  : default almost-empty threshold
package cam_pkg;

   localparam int CAM_PIX_WIDTH      = 10;
   localparam int CAM_FIFO_ADR_WIDTH = 16;
   localparam int CAM_FIFO_AF_MARGIN = 4;
   localparam int CAM_FIFO_AE_THRESH = 4;

   function automatic int cam_fifo_af_default(input int adr_width);
      return (2 ** adr_width) - CAM_FIFO_AF_MARGIN;
   endfunction

endpackage

// File: rtl/cam_fifo_ram.sv
// Simple dual-port RAM for the camera stream FIFO.
//   Pclk, rst_n   : clock, async active-low reset (read register only)
//   we/waddr/wdata: write port
//   re/raddr      : read port; re loads the read register
//   rdata         : async mem[raddr] when REG_READ=0, registered otherwise
// The array itself is not reset.
module cam_fifo_ram #(
   parameter int DAT_WIDTH = 10,
   parameter int ADR_WIDTH = 4,
   parameter bit REG_READ  = 1'b0
) (
   input  logic                 Pclk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [ADR_WIDTH-1:0] waddr,
   input  logic [DAT_WIDTH-1:0] wdata,
   input  logic                 re,
   input  logic [ADR_WIDTH-1:0] raddr,
   output logic [DAT_WIDTH-1:0] rdata
);

   logic [DAT_WIDTH-1:0] mem [2**ADR_WIDTH];
   logic [DAT_WIDTH-1:0] rd_q;

   always_ff @(posedge Pclk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Non-blocking update gives read-before-write when raddr == waddr.
   always_ff @(posedge Pclk or negedge rst_n) begin
      if (!rst_n)  rd_q <= '0;
      else if (re) rd_q <= mem[raddr];
   end

   assign rdata = REG_READ ? rd_q : mem[raddr];

endmodule

// File: rtl/cam_stream_fifo.sv
// Camera stream FIFO with show-ahead or registered read, occupancy level,
// almost-full/almost-empty thresholds, synchronous flush and sticky errors.
//   Pclk, rst_n          : clock, async active-low reset
//   wr, data_in          : write request and data
//   rd                   : read request
//   data_out, data_valid : read data and its qualifier
//   flush                : synchronous clear of contents (errors untouched)
//   err_clr              : clears overflow/underflow
//   empty, full, almost_empty, almost_full, level : occupancy status
//   overflow, underflow  : sticky rejected-write / rejected-read flags
module cam_stream_fifo
   import cam_pkg::*;
#(
   parameter int DAT_WIDTH  = CAM_PIX_WIDTH,
   parameter int ADR_WIDTH  = CAM_FIFO_ADR_WIDTH,
   parameter int AF_THRESH  = cam_fifo_af_default(ADR_WIDTH),
   parameter int AE_THRESH  = CAM_FIFO_AE_THRESH,
   parameter bit SHOW_AHEAD = 1'b1
) (
   input  logic                 Pclk,
   input  logic                 rst_n,
   input  logic                 wr,
   input  logic [DAT_WIDTH-1:0] data_in,
   input  logic                 rd,
   output logic [DAT_WIDTH-1:0] data_out,
   output logic                 data_valid,
   input  logic                 flush,
   input  logic                 err_clr,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_empty,
   output logic                 almost_full,
   output logic [ADR_WIDTH:0]   level,
   output logic                 overflow,
   output logic                 underflow
);

   localparam logic [ADR_WIDTH:0] DEPTH_L = {1'b1, {ADR_WIDTH{1'b0}}};
   localparam logic [ADR_WIDTH:0] AF_T    = AF_THRESH[ADR_WIDTH:0];
   localparam logic [ADR_WIDTH:0] AE_T    = AE_THRESH[ADR_WIDTH:0];
   localparam logic [ADR_WIDTH:0] PTR_ONE = {{ADR_WIDTH{1'b0}}, 1'b1};

   logic [ADR_WIDTH:0] w_ptr, r_ptr;
   logic               rd_ok, wr_ok;
   logic               dv_q;

   assign level        = w_ptr - r_ptr;
   assign empty        = (level == '0);
   assign full         = (level == DEPTH_L);
   assign almost_empty = (level <= AE_T);
   assign almost_full  = (level >= AF_T);

   // Flush masks both requests so that they neither move pointers nor
   // raise errors. A full FIFO still accepts a write paired with a read.
   assign rd_ok = rd & ~flush & ~empty;
   assign wr_ok = wr & ~flush & (~full | rd_ok);

   always_ff @(posedge Pclk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr <= '0;
         r_ptr <= '0;
      end else if (flush) begin
         w_ptr <= '0;
         r_ptr <= '0;
      end else begin
         if (wr_ok) w_ptr <= w_ptr + PTR_ONE;
         if (rd_ok) r_ptr <= r_ptr + PTR_ONE;
      end
   end

   // A set in the same cycle as err_clr takes priority.
   always_ff @(posedge Pclk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         dv_q      <= 1'b0;
      end else begin
         if (wr & ~flush & ~wr_ok) overflow <= 1'b1;
         else if (err_clr)         overflow <= 1'b0;
         if (rd & ~flush & ~rd_ok) underflow <= 1'b1;
         else if (err_clr)         underflow <= 1'b0;
         dv_q <= rd_ok;
      end
   end

   assign data_valid = SHOW_AHEAD ? ~empty : dv_q;

   cam_fifo_ram #(
      .DAT_WIDTH (DAT_WIDTH),
      .ADR_WIDTH (ADR_WIDTH),
      .REG_READ  (!SHOW_AHEAD)
   ) u_ram (
      .Pclk  (Pclk),
      .rst_n (rst_n),
      .we    (wr_ok),
      .waddr (w_ptr[ADR_WIDTH-1:0]),
      .wdata (data_in),
      .re    (rd_ok),
      .raddr (r_ptr[ADR_WIDTH-1:0]),
      .rdata (data_out)
   );

endmodule

// File: tb/tb_cam_stream_fifo.sv
module tb_cam_stream_fifo;

   localparam int DW = 10;
   localparam int AW = 4;

   logic          Pclk = 1'b0;
   logic          rst_n;
   logic          wr, rd, flush, err_clr;
   logic [DW-1:0] data_in;

   logic [DW-1:0] sa_dout, rg_dout;
   logic          sa_dv, rg_dv;
   logic          sa_empty, sa_full, sa_ae, sa_af, sa_ovf, sa_unf;
   logic          rg_empty, rg_full, rg_ae, rg_af, rg_ovf, rg_unf;
   logic [AW:0]   sa_level, rg_level;

   always #5 Pclk = ~Pclk;

   cam_stream_fifo #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .AF_THRESH(12),
                     .AE_THRESH(2), .SHOW_AHEAD(1'b1)) u_sa (
      .Pclk(Pclk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
      .data_out(sa_dout), .data_valid(sa_dv), .flush(flush), .err_clr(err_clr),
      .empty(sa_empty), .full(sa_full), .almost_empty(sa_ae), .almost_full(sa_af),
      .level(sa_level), .overflow(sa_ovf), .underflow(sa_unf));

   cam_stream_fifo #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .AF_THRESH(12),
                     .AE_THRESH(2), .SHOW_AHEAD(1'b0)) u_rg (
      .Pclk(Pclk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
      .data_out(rg_dout), .data_valid(rg_dv), .flush(flush), .err_clr(err_clr),
      .empty(rg_empty), .full(rg_full), .almost_empty(rg_ae), .almost_full(rg_af),
      .level(rg_level), .overflow(rg_ovf), .underflow(rg_unf));

   // Reference model: a plain queue of words plus sticky flags.
   logic [DW-1:0] q[$];
   bit            m_ovf, m_unf, m_rdv;
   logic [DW-1:0] m_dout;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic model_clear();
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0; m_dout = '0;
   endtask

   task automatic do_reset();
      wr = 0; rd = 0; flush = 0; err_clr = 0; data_in = '0;
      rst_n = 0;
      model_clear();
      repeat (2) @(posedge Pclk);
      #1 rst_n = 1;
   endtask

   // One clock: drive inputs, apply the edge to the model, settle.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit f, input bit ec);
      bit r_acc, w_acc;
      wr = w; data_in = d; rd = r; flush = f; err_clr = ec;
      @(posedge Pclk);
      if (f) begin
         q.delete();
         m_rdv = 0;
         if (ec) begin m_ovf = 0; m_unf = 0; end
      end else begin
         r_acc = r && (q.size() > 0);
         w_acc = w && (q.size() < 16 || r_acc);
         m_rdv = r_acc;
         if (r_acc) m_dout = q.pop_front();
         if (w_acc) q.push_back(d);
         if (w && !w_acc) m_ovf = 1; else if (ec) m_ovf = 0;
         if (r && !r_acc) m_unf = 1; else if (ec) m_unf = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if ({sa_empty, rg_empty, sa_ae, rg_ae} !== 4'hF) $display("FAIL reset_empty_ae got %b exp 1111", {sa_empty, rg_empty, sa_ae, rg_ae}); else n_pass++;
      n_checks++; if ({sa_full, rg_full, sa_af, rg_af} !== 4'h0) $display("FAIL reset_full_af got %b exp 0000", {sa_full, rg_full, sa_af, rg_af}); else n_pass++;
      n_checks++; if ({sa_ovf, sa_unf, rg_ovf, rg_unf, sa_dv, rg_dv} !== 6'h0) $display("FAIL reset_flags got %b exp 000000", {sa_ovf, sa_unf, rg_ovf, rg_unf, sa_dv, rg_dv}); else n_pass++;
      n_checks++; if (sa_level !== 5'd0 || rg_level !== 5'd0) $display("FAIL reset_level got %0d/%0d exp 0", sa_level, rg_level); else n_pass++;
      n_checks++; if (rg_dout !== 10'h000) $display("FAIL reset_rg_dout got %h exp 000", rg_dout); else n_pass++;
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         step(1, 10'(k), 0, 0, 0);
         n_checks++; if (sa_level !== 5'(k) || rg_level !== 5'(k)) $display("FAIL fill_level got %0d/%0d exp %0d", sa_level, rg_level, k); else n_pass++;
         n_checks++; if (sa_af !== (k >= 12) || rg_af !== (k >= 12)) $display("FAIL fill_af got %b/%b exp %b at level %0d", sa_af, rg_af, k >= 12, k); else n_pass++;
         n_checks++; if (sa_full !== (k == 16) || sa_ae !== (k <= 2)) $display("FAIL fill_full_ae got %b%b exp %b%b", sa_full, sa_ae, k == 16, k <= 2); else n_pass++;
      end
      for (int k = 1; k <= 16; k++) begin
         n_checks++; if (sa_dout !== 10'(k) || sa_dv !== 1'b1) $display("FAIL drain_sa got %h dv %b exp %h", sa_dout, sa_dv, 10'(k)); else n_pass++;
         step(0, '0, 1, 0, 0);
         n_checks++; if (rg_dout !== 10'(k) || rg_dv !== 1'b1) $display("FAIL drain_rg got %h dv %b exp %h", rg_dout, rg_dv, 10'(k)); else n_pass++;
      end
      step(0, '0, 0, 0, 0);
      n_checks++; if (sa_empty !== 1 || rg_empty !== 1 || rg_dv !== 0 || sa_dv !== 0) $display("FAIL drain_end got empty %b%b dv %b%b exp 11 00", sa_empty, rg_empty, sa_dv, rg_dv); else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 0; k < 16; k++) step(1, 10'(k + 32), 0, 0, 0);
      n_checks++; if (sa_ovf !== 0 || rg_ovf !== 0) $display("FAIL ovf_early got %b%b exp 00", sa_ovf, rg_ovf); else n_pass++;
      step(1, 10'h155, 0, 0, 0);
      n_checks++; if (sa_ovf !== 1 || rg_ovf !== 1 || sa_level !== 5'd16) $display("FAIL ovf_set got %b%b level %0d exp 11 16", sa_ovf, rg_ovf, sa_level); else n_pass++;
      step(0, '0, 0, 0, 0);
      n_checks++; if (sa_ovf !== 1) $display("FAIL ovf_sticky got %b exp 1", sa_ovf); else n_pass++;
      step(0, '0, 0, 0, 1);
      n_checks++; if (sa_ovf !== 0 || rg_ovf !== 0) $display("FAIL ovf_clr got %b%b exp 00", sa_ovf, rg_ovf); else n_pass++;
      // set beats clear in the same cycle
      step(1, 10'h001, 0, 0, 1);
      n_checks++; if (sa_ovf !== 1 || rg_ovf !== 1) $display("FAIL ovf_set_wins got %b%b exp 11", sa_ovf, rg_ovf); else n_pass++;
   endtask

   task automatic test_empty_rdwr();
      do_reset();
      step(1, 10'h2AA, 1, 0, 0);
      n_checks++; if (sa_level !== 5'd1 || sa_unf !== 1 || rg_unf !== 1) $display("FAIL erw_state got level %0d unf %b%b exp 1 11", sa_level, sa_unf, rg_unf); else n_pass++;
      n_checks++; if (rg_dv !== 0 || sa_ovf !== 0) $display("FAIL erw_side got dv %b ovf %b exp 0 0", rg_dv, sa_ovf); else n_pass++;
      n_checks++; if (sa_dout !== 10'h2AA) $display("FAIL erw_sa got %h exp 2aa", sa_dout); else n_pass++;
      step(0, '0, 1, 0, 0);
      n_checks++; if (rg_dout !== 10'h2AA || rg_dv !== 1) $display("FAIL erw_rg got %h dv %b exp 2aa 1", rg_dout, rg_dv); else n_pass++;
   endtask

   task automatic test_full_rdwr();
      logic [DW-1:0] vals [16];
      logic [DW-1:0] exp_v;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         vals[k] = 10'($urandom_range(0, 1022));
         step(1, vals[k], 0, 0, 0);
      end
      for (int k = 0; k < 20; k++) begin
         exp_v = (k < 16) ? vals[k] : 10'h3FF;
         n_checks++; if (sa_dout !== exp_v) $display("FAIL frw_sa k=%0d got %h exp %h", k, sa_dout, exp_v); else n_pass++;
         step(1, 10'h3FF, 1, 0, 0);
         n_checks++; if (rg_dout !== exp_v || rg_dv !== 1) $display("FAIL frw_rg k=%0d got %h dv %b exp %h", k, rg_dout, rg_dv, exp_v); else n_pass++;
         n_checks++; if (sa_level !== 5'd16 || rg_level !== 5'd16 || sa_ovf !== 0 || rg_ovf !== 0) $display("FAIL frw_level k=%0d got %0d/%0d ovf %b%b exp 16 00", k, sa_level, rg_level, sa_ovf, rg_ovf); else n_pass++;
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 7; k++) step(1, 10'(k + 100), 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(1, 10'h050, 0, 0, 0);
      n_checks++; if (sa_level !== 5'd7) $display("FAIL flush_pre got %0d exp 7", sa_level); else n_pass++;
      step(1, 10'h077, 1, 1, 0);
      n_checks++; if (sa_level !== 5'd0 || rg_level !== 5'd0 || sa_empty !== 1 || rg_empty !== 1) $display("FAIL flush_level got %0d/%0d empty %b%b exp 0 11", sa_level, rg_level, sa_empty, rg_empty); else n_pass++;
      n_checks++; if ({sa_ovf, sa_unf, rg_ovf, rg_unf} !== 4'h0) $display("FAIL flush_err got %b exp 0000", {sa_ovf, sa_unf, rg_ovf, rg_unf}); else n_pass++;
      n_checks++; if (sa_dv !== 0 || rg_dv !== 0) $display("FAIL flush_dv got %b%b exp 00", sa_dv, rg_dv); else n_pass++;
   endtask

   task automatic test_random();
      int wp, rp;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         case ((c / 75) % 4)
            0: begin wp = 85; rp = 20; end
            1: begin wp = 20; rp = 85; end
            2: begin wp = 60; rp = 60; end
            default: begin wp = 95; rp = 50; end
         endcase
         step($urandom_range(99) < wp, 10'($urandom), $urandom_range(99) < rp,
              $urandom_range(99) < 2, $urandom_range(99) < 5);
         n_checks++;
         if (sa_level !== 5'(q.size()) || rg_level !== 5'(q.size()) ||
             sa_empty !== (q.size() == 0) || sa_full !== (q.size() == 16) ||
             sa_ae !== (q.size() <= 2) || sa_af !== (q.size() >= 12) ||
             rg_empty !== (q.size() == 0) || rg_full !== (q.size() == 16) ||
             rg_ae !== (q.size() <= 2) || rg_af !== (q.size() >= 12))
            $display("FAIL rnd_status c=%0d got level %0d e%b f%b ae%b af%b exp level %0d", c, sa_level, sa_empty, sa_full, sa_ae, sa_af, q.size());
         else n_pass++;
         n_checks++;
         if (sa_ovf !== m_ovf || sa_unf !== m_unf || rg_ovf !== m_ovf || rg_unf !== m_unf)
            $display("FAIL rnd_err c=%0d got %b%b/%b%b exp %b%b", c, sa_ovf, sa_unf, rg_ovf, rg_unf, m_ovf, m_unf);
         else n_pass++;
         n_checks++;
         if (rg_dv !== m_rdv || rg_dout !== m_dout || sa_dv !== (q.size() > 0) ||
             (q.size() > 0 && sa_dout !== q[0]))
            $display("FAIL rnd_data c=%0d got rg %h/%b sa %h/%b exp rg %h/%b", c, rg_dout, rg_dv, sa_dout, sa_dv, m_dout, m_rdv);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 5; k++) step(1, 10'(k + 7), 0, 0, 0);
      step(1, 10'h3C3, 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(1, 10'h001, 1, 0, 0);
      wr = 1; rd = 1;
      #2 rst_n = 0;
      #1;
      n_checks++; if (sa_level !== 5'd0 || rg_level !== 5'd0 || sa_empty !== 1 || rg_empty !== 1 || sa_ae !== 1) $display("FAIL arst_level got %0d/%0d empty %b%b exp 0 11", sa_level, rg_level, sa_empty, rg_empty); else n_pass++;
      n_checks++; if ({sa_dv, rg_dv, sa_full, sa_af, sa_ovf, sa_unf} !== 6'h0) $display("FAIL arst_flags got %b exp 000000", {sa_dv, rg_dv, sa_full, sa_af, sa_ovf, sa_unf}); else n_pass++;
      n_checks++; if (rg_dout !== 10'h000) $display("FAIL arst_rg_dout got %h exp 000", rg_dout); else n_pass++;
      wr = 0; rd = 0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_empty_rdwr();
      test_full_rdwr();
      test_flush();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cam_stream_fifo.md
# cam_stream_fifo

Parametrised synchronous FIFO for the camera capture path. It buffers pixel words between the camera capture logic and downstream consumers (frame buffer writer, colour classifier) in the `Pclk` domain. Compared with the single-mode camera FIFO it adds:

- selectable show-ahead or registered read;
- an occupancy count and programmable almost-full/almost-empty thresholds;
- a synchronous flush;
- sticky overflow/underflow error flags.

## Interface
Parameters:
- `DAT_WIDTH`, 10: data word width in bits.
- `ADR_WIDTH`, 16: address width; depth `DEPTH` = 2^`ADR_WIDTH`.
- `AF_THRESH`, `DEPTH`-4: `almost_full` asserted when `level` >= `AF_THRESH`.
- `AE_THRESH`, 4: `almost_empty` asserted when `level` <= `AE_THRESH`.
- `SHOW_AHEAD`, 1: 1 = head word visible on `data_out` without a read; 0 = registered read, data one cycle after `rd`.

Ports:
- `Pclk`, in, 1: the single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `wr`, in, 1: write request.
- `data_in`, in, `DAT_WIDTH`: write data.
- `rd`, in, 1: read request.
- `data_out`, out, `DAT_WIDTH`: read data.
- `data_valid`, out, 1: `data_out` holds valid read data. In show-ahead mode this equals `!empty`; in registered mode it is a 1-cycle pulse.
- `flush`, in, 1: synchronous clear of contents.
- `err_clr`, in, 1: clears the sticky error flags.
- `empty`, out, 1: FIFO holds no words.
- `full`, out, 1: FIFO holds `DEPTH` words.
- `almost_empty`, out, 1: occupancy at or below `AE_THRESH`.
- `almost_full`, out, 1: occupancy at or above `AF_THRESH`.
- `level`, out, `ADR_WIDTH`+1: occupancy, 0..`DEPTH`.
- `overflow`, out, 1: sticky; a write was rejected.
- `underflow`, out, 1: sticky; a read was rejected.

## Operation
- **Pointers.** Write and read pointers are `ADR_WIDTH`+1 bits and wrap modulo 2^(`ADR_WIDTH`+1).
  - `level` = `w_ptr` − `r_ptr`, modulo 2^(`ADR_WIDTH`+1).
  - `empty` = (`level` == 0); `full` = (`level` == `DEPTH`).
- **Read acceptance.** `rd_ok` = `rd` & `!empty`.
- **Write acceptance.** `wr_ok` = `wr` & (`!full` | `rd_ok`). When full, a simultaneous rd+wr is accepted on both sides, `level` is unchanged and the memory is read-before-write.
- **Empty with rd+wr.** The write is accepted, the read is rejected, and `underflow` sets.
- **Error flags.**
  - `wr` & !`wr_ok` sets `overflow`; `rd` & !`rd_ok` sets `underflow`.
  - Both hold until `err_clr`. A set in the same cycle as `err_clr` wins.
- **Flush.**
  - Zeroes both pointers and clears `data_valid` at the next edge.
  - `rd` and `wr` in the same cycle are ignored and raise no error.
  - Error flags are not affected.
- **Show-ahead read (`SHOW_AHEAD`=1).** `data_out` = `mem[r_ptr]` combinationally. It is don't-care while empty.
- **Registered read (`SHOW_AHEAD`=0).**
  - On `rd_ok`, `data_out` <= `mem[r_ptr]` and `data_valid` pulses high for the next cycle.
  - Otherwise `data_out` holds its value.
- **Reset values.**
  - Pointers 0, `empty` 1, `full` 0, `level` 0.
  - `almost_empty` 1, `almost_full` 0.
  - `overflow` 0, `underflow` 0, `data_valid` 0, registered `data_out` 0.
  - The memory array is not reset.

## Timing
- Writes are visible to the read side one cycle after the write edge: `empty` deasserts on the edge that accepts the first write.
- Show-ahead: data is readable in the cycle after the first write, so write-to-`data_out` latency is 1.
- Registered mode: `rd` at cycle N gives `data_out`/`data_valid` at N+1, so write-to-output latency is at least 2.
- All status outputs are decoded from registered pointers/flags, with no combinational path from `rd`/`wr`.
- Status updates on the same edge as the pointer change.
- `rst_n` assertion mid-operation clears state immediately, without waiting for a clock edge. Deassertion is synchronised by the system reset block, not inside this block.

## Structure
- Shared package/header `cam_pkg`: camera pixel width constant (10), default FIFO `ADR_WIDTH`, and threshold defaults.
- Sub-module `cam_fifo_ram`: simple dual-port RAM (1 write port, 1 read port).
  - Parameters `DAT_WIDTH`, `ADR_WIDTH`.
  - Async read for show-ahead mode; registered read selected by a parameter.
- Pointer, flag and level logic stays in `cam_stream_fifo`.

## Test plan
Bench uses `ADR_WIDTH`=4 (`DEPTH` 16), `AF_THRESH`=12, `AE_THRESH`=2, both `SHOW_AHEAD` values.
- **Fill and drain.** Write 0x001..0x010 back-to-back, then read 16 → `full` after the 16th write, `level`=16, `almost_full` from `level` 12; reads return 0x001..0x010 in order; `empty`=1 at end.
- **Overflow.** Write 17 words with `rd`=0 → 17th rejected, `overflow`=1, `level`=16; `err_clr` pulse → `overflow`=0.
- **Empty rd+wr.** Empty FIFO, rd+wr with 0x2AA → `level`=1, `underflow`=1, next read returns 0x2AA.
- **Full rd+wr.** Full FIFO, rd+wr with 0x3FF for 20 cycles → `level` stays 16, no `overflow`, output order is preserved across pointer wrap.
- **Flush.** `flush` with `level`=7 and rd+wr asserted → `level`=0, `empty`=1, no error flags, `data_valid`=0.
- **Async reset.** `rst_n` low mid-stream, asserted between clock edges → all outputs at reset values before the next `Pclk` edge.
